conv_mac_stream: RTL

//  Time-multiplexed fixed-point convolution engine: one signed MAC serially accumulates
//  a K x K x C window of (filter, input) pairs streamed one pair per beat, then adds bias,

---
 rtl/conv_mac_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/conv_mac_stream.sv
// conv_mac_stream: serial signed MAC over a K*K*C window of (filter, data) beats,
// followed by bias add, optional ReLU, round-half-up and saturation to N bits.
module conv_mac_stream #(
   parameter int N = 32,
   parameter int Q = 16,
   parameter int K = 7,
   parameter int C = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_filter,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   input  logic [N-1:0] bias,
   input  logic         relu_en,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         err_last
);
   localparam int TAPS = K * K * C;
   localparam int CW   = $clog2(TAPS + 1);
   localparam int AW   = 2 * N + CW + 1;
   localparam int SW   = AW + 1;
   localparam logic [CW-1:0]        LAST_IDX = CW'(TAPS - 1);
   localparam logic signed [SW-1:0] ROUND_C  = SW'(1) <<< (Q - 1);
   localparam logic signed [SW-1:0] MAX_V    = (SW'(1) <<< (N - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MIN_V    = -(SW'(1) <<< (N - 1));
   localparam logic [N-1:0]         MAX_N    = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]         MIN_N    = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [N-1:0]         bias_q, bias_d;
   logic                 relu_q, relu_d;
   logic                 mismatch_q, mismatch_d;
   logic                 out_valid_q, out_valid_d;
   logic [N-1:0]         out_data_q, out_data_d;

   logic                   accept, first_beat, last_beat, beat_bad;
   logic signed [2*N-1:0]  filter_ext, data_ext, product;
   logic signed [AW-1:0]   product_ext;
   logic signed [SW-1:0]   sum_s, shifted;
   logic [N-1:0]           result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACC;
         count_q     <= '0;
         acc_q       <= '0;
         bias_q      <= '0;
         relu_q      <= 1'b0;
         mismatch_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         bias_q      <= bias_d;
         relu_q      <= relu_d;
         mismatch_q  <= mismatch_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACC:     if (accept && last_beat) state_d = FIN;
         FIN:     state_d = OUT;
         OUT:     if (out_ready) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ACC) && !rst;
      err_last  = (state_q == FIN) && mismatch_q;
      out_valid = out_valid_q;
      out_data  = out_data_q;
   end

   always_comb begin
      accept      = in_valid && in_ready;
      first_beat  = (count_q == '0);
      last_beat   = (count_q == LAST_IDX);
      beat_bad    = (in_last != last_beat);
      filter_ext  = {{N{in_filter[N-1]}}, in_filter};
      data_ext    = {{N{in_data[N-1]}}, in_data};
      product     = filter_ext * data_ext;
      product_ext = {{(AW-2*N){product[2*N-1]}}, product};
   end

   // Bias is aligned to the 2Q product scale before the single rounding shift.
   always_comb begin
      sum_s   = {acc_q[AW-1], acc_q} + ({{(SW-N){bias_q[N-1]}}, bias_q} <<< Q) + ROUND_C;
      shifted = sum_s >>> Q;
      if (relu_q && shifted[SW-1]) result = '0;
      else if (shifted > MAX_V)    result = MAX_N;
      else if (shifted < MIN_V)    result = MIN_N;
      else                         result = shifted[N-1:0];
   end

   always_comb begin
      count_d     = count_q;
      acc_d       = acc_q;
      bias_d      = bias_q;
      relu_d      = relu_q;
      mismatch_d  = mismatch_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         count_d = last_beat ? '0 : count_q + CW'(1);
         if (first_beat) begin
            acc_d      = product_ext;
            bias_d     = bias;
            relu_d     = relu_en;
            mismatch_d = beat_bad;
         end else begin
            acc_d      = acc_q + product_ext;
            mismatch_d = mismatch_q | beat_bad;
         end
      end
      if (state_q == FIN) begin
         out_data_d  = result;
         out_valid_d = 1'b1;
      end
      if (state_q == OUT && out_ready) out_valid_d = 1'b0;
   end
endmodule
